// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX hazard scoreboard: op classes, FSM states,
// forward-select encoding and the per-class availability rule.
package pipe_pkg;

    localparam logic [1:0] CLASS_ALU  = 2'd0;
    localparam logic [1:0] CLASS_LOAD = 2'd1;
    localparam logic [1:0] CLASS_MUL  = 2'd2;
    localparam logic [1:0] CLASS_LINK = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_e;

    // Forward select 0 means "take the operand from the write-through regfile".
    localparam int FSEL_REGFILE = 0;

    // Earliest table index a producer must occupy for its result to be forwardable.
    // Loads deliver data out of MEM; ALU, LINK and MUL results exist once out of EX.
    function automatic int avail_stage(input logic [1:0] cls);
        return (cls == CLASS_LOAD) ? 2 : 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Priority match of one source register against the in-flight destination table.
// Youngest (lowest index) valid match wins; reports whether it is forwardable next cycle.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int IDX_W  = 2
) (
    input  logic [DEPTH-1:0]             tbl_vld,
    input  logic [DEPTH-1:0][REG_AW-1:0] tbl_rd,
    input  logic [DEPTH-1:0][1:0]        tbl_cls,
    input  logic [REG_AW-1:0]            rs,
    input  logic                         use_src,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx,
    output logic                         avail
);

    // Scan oldest to youngest so the lowest matching index is the last one written.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        avail = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (use_src && (rs != '0) && tbl_vld[i] && (tbl_rd[i] == rs)) begin
                hit   = 1'b1;
                idx   = IDX_W'(i);
                // The producer will sit at i+1 when the consumer reaches EX.
                avail = ((i + 1) >= avail_stage(tbl_cls[i]));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: tracks in-flight destinations, registers per-source
// forward selects, raises load-use / multicycle stalls and sequences redirect flushes.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter  int REG_AW    = 5,
    parameter  int DEPTH     = 3,
    parameter  int NSRC      = 2,
    parameter  int MUL_LAT   = 4,
    parameter  int REDIR_CYC = 2,
    localparam int FSEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NSRC*REG_AW-1:0]   id_rs,
    input  logic [NSRC-1:0]          id_uses,
    input  logic                     id_rd_we,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic [1:0]               id_class,
    input  logic                     ex_redirect,
    output logic                     stall_id,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic [NSRC*FSEL_W-1:0]   fwd_sel,
    output logic                     ex_hold
);

    localparam int CNT_MAX = (MUL_LAT > REDIR_CYC) ? MUL_LAT : REDIR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][1:0]        cls_q, cls_d;
    hz_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NSRC-1:0][FSEL_W-1:0]  fsel_q, fsel_d;

    logic [NSRC-1:0]              hit, avail;
    logic [NSRC-1:0][FSEL_W-1:0]  idx;
    logic                         busy, redirect, raw_stall, advance, go_mul;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        hazard_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .IDX_W  (FSEL_W)
        ) u_match (
            .tbl_vld (vld_q),
            .tbl_rd  (rd_q),
            .tbl_cls (cls_q),
            .rs      (id_rs[g*REG_AW +: REG_AW]),
            .use_src (id_uses[g]),
            .hit     (hit[g]),
            .idx     (idx[g]),
            .avail   (avail[g])
        );
    end

    // Stall / flush decisions; a redirect overrides any pending data hazard, and
    // a redirect while a MUL holds EX cannot be real so it is ignored.
    always_comb begin
        busy      = (state_q == ST_MUL_BUSY);
        redirect  = ex_redirect && !busy;
        raw_stall = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (hit[k] && !avail[k]) raw_stall = 1'b1;
        end
        stall_id    = id_valid && !redirect && (busy || raw_stall);
        flush_id_ex = redirect;
        flush_if_id = redirect || (state_q == ST_FLUSH);
        ex_hold     = busy;
        advance     = id_valid && !stall_id && !redirect;
        go_mul      = advance && (id_class == CLASS_MUL);
    end

    // Destination table shift; while a MUL holds EX, index 0 freezes and a bubble opens at 1.
    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        cls_d = cls_q;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
            cls_d[i] = cls_q[i-1];
        end
        if (busy) begin
            vld_d[0] = vld_q[0];
            rd_d[0]  = rd_q[0];
            cls_d[0] = cls_q[0];
            vld_d[1] = 1'b0;
        end else begin
            vld_d[0] = advance && id_rd_we && (id_rd != '0);
            rd_d[0]  = id_rd;
            cls_d[0] = id_class;
        end
    end

    // Control FSM: MUL occupancy countdown and redirect flush tail.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_FLUSH: begin
                if (redirect) begin
                    // A redirect during FLUSH restarts the tail count.
                    if (REDIR_CYC > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(REDIR_CYC - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (go_mul) begin
                    state_d = ST_MUL_BUSY;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end else if (state_q == ST_FLUSH) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_MUL_BUSY: begin
                // The MUL spends MUL_LAT-1 held cycles plus its completing cycle in EX.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Forward selects follow the instruction into EX and hold while it waits in ID.
    always_comb begin
        fsel_d = fsel_q;
        if (advance) begin
            for (int k = 0; k < NSRC; k++) begin
                fsel_d[k] = (hit[k] && avail[k]) ? (idx[k] + FSEL_W'(1))
                                                 : FSEL_W'(FSEL_REGFILE);
            end
        end
    end

    assign fwd_sel = fsel_q;

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            rd_q    <= '0;
            cls_q   <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fsel_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            cls_q   <= cls_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fsel_q  <= fsel_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (defaults: DEPTH=3, NSRC=2, MUL_LAT=4, REDIR_CYC=2).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_hazard_scoreboard;
    import pipe_pkg::*;

    localparam int REG_AW = 5;
    localparam int NSRC   = 2;
    localparam int FSEL_W = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   id_valid = 1'b0;
    logic [NSRC*REG_AW-1:0] id_rs = '0;
    logic [NSRC-1:0]        id_uses = '0;
    logic                   id_rd_we = 1'b0;
    logic [REG_AW-1:0]      id_rd = '0;
    logic [1:0]             id_class = '0;
    logic                   ex_redirect = 1'b0;
    logic                   stall_id, flush_if_id, flush_id_ex, ex_hold;
    logic [NSRC*FSEL_W-1:0] fwd_sel;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_uses     (id_uses),
        .id_rd_we    (id_rd_we),
        .id_rd       (id_rd),
        .id_class    (id_class),
        .ex_redirect (ex_redirect),
        .stall_id    (stall_id),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .fwd_sel     (fwd_sel),
        .ex_hold     (ex_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // r1 drives source 1, r0 drives source 0; u[k] marks source k as read.
    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r0,
                          input logic [1:0] u, input logic we, input logic [4:0] rd,
                          input logic [1:0] cls);
        id_valid = v;
        id_rs    = {r1, r0};
        id_uses  = u;
        id_rd_we = we;
        id_rd    = rd;
        id_class = cls;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_id(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, CLASS_ALU);
            ex_redirect = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        chk("rst_stall", stall_id, 0);
        chk("rst_flush_if", flush_if_id, 0);
        chk("rst_flush_ex", flush_id_ex, 0);
        chk("rst_hold", ex_hold, 0);
        chk("rst_fwd", fwd_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: add x5; sub reads x5 on both sources -> forward from MEM (1) on both
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd5, CLASS_ALU); #1;
        chk("t1_add_stall", stall_id, 0);
        @(negedge clk); set_id(1, 5'd5, 5'd5, 2'b11, 1, 5'd9, CLASS_ALU); #1;
        chk("t1_sub_stall", stall_id, 0);
        idle(1); #1;
        chk("t1_fwd", fwd_sel, 4'b0101);
        idle(3);

        // 2: lw x6; add reads x6 -> one bubble, then forward select 2
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd6, CLASS_LOAD); #1;
        chk("t2_lw_stall", stall_id, 0);
        @(negedge clk); set_id(1, 5'd0, 5'd6, 2'b01, 1, 5'd10, CLASS_ALU); #1;
        chk("t2_loaduse_stall", stall_id, 1);
        @(negedge clk); #1;
        chk("t2_fwd_held", fwd_sel, 0);
        chk("t2_stall_clears", stall_id, 0);
        idle(1); #1;
        chk("t2_fwd", fwd_sel, 4'b0010);
        idle(3);
        // 2b: load into x0 never creates a dependency
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd0, CLASS_LOAD);
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b01, 1, 5'd10, CLASS_ALU); #1;
        chk("t2_x0_stall", stall_id, 0);
        idle(1); #1;
        chk("t2_x0_fwd", fwd_sel, 0);
        idle(3);

        // 3: addi x7, lw x7, add reads x7 -> lw (youngest) decides
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd7, CLASS_ALU);
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd7, CLASS_LOAD);
        @(negedge clk); set_id(1, 5'd0, 5'd7, 2'b01, 1, 5'd11, CLASS_ALU); #1;
        chk("t3_stall", stall_id, 1);
        @(negedge clk); #1;
        chk("t3_stall_clears", stall_id, 0);
        idle(1); #1;
        chk("t3_fwd", fwd_sel, 4'b0010);
        idle(3);

        // 4: mul x8 -> three held cycles, then dependent add forwards from index 0
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd8, CLASS_MUL); #1;
        chk("t4_mul_stall", stall_id, 0);
        chk("t4_mul_hold", ex_hold, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_id(1, 5'd8, 5'd3, 2'b11, 1, 5'd11, CLASS_ALU);
            ex_redirect = (c == 1);
            #1;
            chk("t4_busy_hold", ex_hold, 1);
            chk("t4_busy_stall", stall_id, 1);
            chk("t4_busy_noflush", flush_if_id, 0);
        end
        @(negedge clk); ex_redirect = 1'b0; #1;
        chk("t4_done_hold", ex_hold, 0);
        chk("t4_done_stall", stall_id, 0);
        idle(1); #1;
        chk("t4_fwd", fwd_sel, 4'b0100);
        idle(3);

        // 5: redirect beats a load-use stall; the flushed add must not enter the table
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd6, CLASS_LOAD);
        @(negedge clk); set_id(1, 5'd0, 5'd6, 2'b01, 1, 5'd6, CLASS_ALU); ex_redirect = 1'b1; #1;
        chk("t5_stall", stall_id, 0);
        chk("t5_flush_if", flush_if_id, 1);
        chk("t5_flush_ex", flush_id_ex, 1);
        idle(1); #1;
        chk("t5_tail_flush_if", flush_if_id, 1);
        chk("t5_tail_flush_ex", flush_id_ex, 0);
        chk("t5_tail_stall", stall_id, 0);
        @(negedge clk); set_id(1, 5'd0, 5'd6, 2'b01, 1, 5'd12, CLASS_ALU); #1;
        chk("t5_end_flush_if", flush_if_id, 0);
        chk("t5_after_stall", stall_id, 0);
        idle(1); #1;
        chk("t5_fwd_wb", fwd_sel, 4'b0011);
        idle(3);

        // 6: reset during MUL_BUSY clears everything asynchronously
        @(negedge clk); set_id(1, 5'd0, 5'd0, 2'b00, 1, 5'd8, CLASS_MUL);
        @(negedge clk); set_id(1, 5'd5, 5'd8, 2'b11, 1, 5'd12, CLASS_ALU); #1;
        chk("t6_busy", ex_hold, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_hold", ex_hold, 0);
        chk("t6_rst_stall", stall_id, 0);
        chk("t6_rst_flush", flush_if_id, 0);
        chk("t6_rst_fwd", fwd_sel, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("t6_post_stall", stall_id, 0);
        chk("t6_post_hold", ex_hold, 0);
        idle(1); #1;
        chk("t6_post_fwd", fwd_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
